// File: rtl/keccak_padder.sv
// keccak_padder: input stage of the keccak core. Packs 64-bit message words
// into rate-sized blocks, applies SHA-3 domain padding (0x06 ... 0x80) and
// presents each finished block to the f-permutation over valid/ready.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   start      begin a new hash: clears the buffer and latches mode
//   mode       00 SHA3-224 (18 words), 01 SHA3-256 (17),
//              10 SHA3-384 (13), 11 SHA3-512 (9)
//   in         message word, byte i at bits 8i+7:8i
//   in_valid   in / is_last / byte_num are valid
//   is_last    current word is the final message word
//   byte_num   valid bytes in the final word (0..7)
//   ack        combinational, word accepted this cycle
//   out        block, word k at bits 64k+63:64k, words past the rate read 0
//   out_valid  block complete and held stable
//   out_ready  permutation takes the block
//   out_last   block is the final padded block of the message
//   busy       padder is not idle
module keccak_padder #(
    parameter int W         = 64,
    parameter int MAX_WORDS = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [W-1:0]           in,
    input  logic                   in_valid,
    input  logic                   is_last,
    input  logic [2:0]             byte_num,
    output logic                   ack,
    output logic [MAX_WORDS*W-1:0] out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int NB = W / 8;
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        PAD    = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rate_r;
    logic [W-1:0]  buf_q [MAX_WORDS];
    logic          at_end;

    // Rate in 64-bit words for each SHA-3 variant.
    function automatic logic [CW-1:0] rate_of(input logic [1:0] m);
        logic [CW-1:0] r;
        r = CW'(MAX_WORDS);
        unique case (m)
            2'b00: r = CW'(18);
            2'b01: r = CW'(17);
            2'b10: r = CW'(13);
            2'b11: r = CW'(9);
        endcase
        return r;
    endfunction

    // Final message word: keep the n valid bytes, put the 0x06 domain byte
    // right after them, zero the rest. When this word also closes the block
    // the 0x80 terminator lands in the top byte (0x86 if they coincide).
    function automatic logic [W-1:0] pad_last(
        input logic [W-1:0] d,
        input logic [2:0]   n,
        input logic         close
    );
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(n)) begin
                r[8*i +: 8] = d[8*i +: 8];
            end else if (i == int'(n)) begin
                r[8*i +: 8] = 8'h06;
            end
        end
        if (close) begin
            r[W-1 -: 8] = r[W-1 -: 8] | 8'h80;
        end
        return r;
    endfunction

    assign ack    = (state == ABSORB) && in_valid && !start;
    assign at_end = (cnt == rate_r - CW'(1));

    // Buffer is cleared at every block boundary and only words below the
    // rate are ever written, so words past the rate always read zero.
    for (genvar k = 0; k < MAX_WORDS; k++) begin : g_out
        assign out[k*W +: W] = buf_q[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rate_r    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < MAX_WORDS; k++) begin
                buf_q[k] <= '0;
            end
        end else if (start) begin
            // Restart wins over everything, dropping any in-flight block.
            state     <= ABSORB;
            rate_r    <= rate_of(mode);
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b1;
            for (int k = 0; k < MAX_WORDS; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                ABSORB: begin
                    if (ack) begin
                        if (is_last) begin
                            buf_q[cnt] <= pad_last(in, byte_num, at_end);
                            if (at_end) begin
                                state     <= FULL;
                                out_valid <= 1'b1;
                                out_last  <= 1'b1;
                            end else begin
                                cnt   <= cnt + CW'(1);
                                state <= PAD;
                            end
                        end else begin
                            buf_q[cnt] <= in;
                            if (at_end) begin
                                state     <= FULL;
                                out_valid <= 1'b1;
                                out_last  <= 1'b0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                end
                PAD: begin
                    // One zero word per cycle; the last rate word carries
                    // the 0x80 terminator in its top byte.
                    if (at_end) begin
                        buf_q[cnt] <= {1'b1, {(W-1){1'b0}}};
                        state      <= FULL;
                        out_valid  <= 1'b1;
                        out_last   <= 1'b1;
                    end else begin
                        buf_q[cnt] <= '0;
                        cnt        <= cnt + CW'(1);
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= out_last ? IDLE : ABSORB;
                        busy      <= !out_last;
                        for (int k = 0; k < MAX_WORDS; k++) begin
                            buf_q[k] <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// tb_keccak_padder: vector table, hand-written corner sequences and random
// messages checked against a byte-level SHA-3 padding model.
module tb_keccak_padder;

    localparam int W  = 64;
    localparam int MW = 18;
    localparam logic [63:0] FILL = 64'h0101_0101_0101_0101;
    localparam logic [63:0] TOP  = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      mode;
    logic [63:0]     in_w;
    logic            in_valid;
    logic            is_last;
    logic [2:0]      byte_num;
    logic            ack;
    logic [MW*W-1:0] out_blk;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keccak_padder #(.W(W), .MAX_WORDS(MW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .in       (in_w),
        .in_valid (in_valid),
        .is_last  (is_last),
        .byte_num (byte_num),
        .ack      (ack),
        .out      (out_blk),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy)
    );

    typedef struct {
        logic [1:0]  m;
        int          nfull;
        logic [2:0]  bn;
        logic [63:0] last;
        int          ia;
        logic [63:0] wa;
        int          ib;
        logic [63:0] wb;
        int          ic;
        logic [63:0] wc;
        int          pad;
    } vec_t;

    vec_t tv [7];

    function automatic logic [63:0] word_of(input int k);
        return out_blk[64*k +: 64];
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] m,
                         input logic [63:0] d, input logic v,
                         input logic l, input logic [2:0] bn,
                         input logic r);
        @(negedge clk);
        start     = s;
        mode      = m;
        in_w      = d;
        in_valid  = v;
        is_last   = l;
        byte_num  = bn;
        out_ready = r;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'($urandom), 64'($urandom), 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic send_word(input logic [63:0] d, input logic l,
                             input logic [2:0] bn);
        int n;
        n = 0;
        do begin
            drive(1'b0, 2'($urandom), d, 1'b1, l, bn, 1'b0);
            n++;
        end while (!ack && n < 50);
        chk1("send_ack", ack, 1'b1);
    endtask

    task automatic wait_full(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            idle();
            if (!out_valid) n++;
        end
        chk1("full_seen", out_valid, 1'b1);
    endtask

    task automatic handshake();
        drive(1'b0, 2'($urandom), 64'($urandom), 1'b0, 1'b0, 3'd0, 1'b1);
        chk1("hs_valid", out_valid, 1'b1);
        idle();
        chk1("hs_drop", out_valid, 1'b0);
    endtask

    logic [63:0]     sent [MW];
    logic [MW*W-1:0] snap;
    logic [MW*W-1:0] prev;
    logic            prev_last;
    logic            hold;
    logic            seen;
    logic [1:0]      rm;
    logic [2:0]      rbn;
    logic [63:0]     d;
    logic [63:0]     ew;
    logic            v;
    logic [7:0]      msg [$];
    logic [7:0]      pb  [$];
    int              n, rate, len, nfull, nblk, widx, bi, cyc;

    initial begin
        tv[0] = '{2'b01, 0, 3'd0, 64'hDEAD_BEEF_0BAD_F00D,
                  0, 64'h06, 16, TOP, 17, 64'h0, 16};
        tv[1] = '{2'b11, 8, 3'd7, 64'hFFEE_DDCC_BBAA_9988,
                  8, 64'h86EE_DDCC_BBAA_9988, 7, FILL + 64'd7, 9, 64'h0, 0};
        tv[2] = '{2'b10, 0, 3'd0, 64'h1234_5678_9ABC_DEF0,
                  0, 64'h06, 12, TOP, 13, 64'h0, 12};
        tv[3] = '{2'b00, 3, 3'd3, 64'hAABB_CCDD_EE33_2211,
                  3, 64'h0633_2211, 17, TOP, 2, FILL + 64'd2, 14};
        tv[4] = '{2'b10, 12, 3'd5, 64'h1122_3344_5566_7788,
                  12, 64'h8000_0644_5566_7788, 0, FILL, 11, FILL + 64'd11, 0};
        tv[5] = '{2'b11, 2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                  2, 64'h06, 8, TOP, 1, FILL + 64'd1, 6};
        tv[6] = '{2'b00, 17, 3'd1, 64'h5555_5555_5555_55AB,
                  17, 64'h8000_0000_0000_06AB, 16, FILL + 64'd16, 0, FILL, 0};

        rst = 1'b0;
        start = 1'b0;
        mode = 2'b00;
        in_w = '0;
        in_valid = 1'b0;
        is_last = 1'b0;
        byte_num = 3'd0;
        out_ready = 1'b0;
        #1;
        chk1("rst_ack", ack, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_last", out_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out_zero", out_blk == '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // IDLE ignores input words
        drive(1'b0, 2'b01, 64'h1, 1'b1, 1'b0, 3'd0, 1'b0);
        chk1("idle_ack", ack, 1'b0);
        chk1("idle_busy", busy, 1'b0);

        // single-block vector table
        foreach (tv[i]) begin
            drive(1'b1, tv[i].m, 64'hA5A5, 1'b1, 1'b0, 3'd0, 1'b0);
            chk1("tv_start_ack", ack, 1'b0);
            for (int j = 0; j < tv[i].nfull; j++) begin
                send_word(FILL + 64'(j), 1'b0, 3'($urandom));
            end
            send_word(tv[i].last, 1'b1, tv[i].bn);
            wait_full(n);
            chk("tv_pad_cycles", 64'(n), 64'(tv[i].pad));
            chk1("tv_last", out_last, 1'b1);
            chk("tv_word_a", word_of(tv[i].ia), tv[i].wa);
            chk("tv_word_b", word_of(tv[i].ib), tv[i].wb);
            chk("tv_word_c", word_of(tv[i].ic), tv[i].wc);
            handshake();
            chk1("tv_busy_done", busy, 1'b0);
        end

        // SHA3-224 two blocks with backpressure on the first
        drive(1'b1, 2'b00, 64'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int j = 0; j < MW; j++) begin
            sent[j] = {32'($urandom), 32'(j)};
            send_word(sent[j], 1'b0, 3'd0);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'($urandom), 64'hCAFE, 1'b1, 1'b0, 3'd0, 1'b0);
            chk1("bp_ack", ack, 1'b0);
            chk1("bp_valid", out_valid, 1'b1);
            if (i == 0) snap = out_blk;
            else chk1("bp_stable", out_blk === snap, 1'b1);
        end
        chk1("mb_last1", out_last, 1'b0);
        for (int k = 0; k < MW; k++) begin
            chk("mb_word", word_of(k), sent[k]);
        end
        drive(1'b0, 2'b11, 64'hCAFE, 1'b1, 1'b0, 3'd0, 1'b1);
        chk1("bp_hs_ack", ack, 1'b0);
        chk1("bp_hs_valid", out_valid, 1'b1);
        send_word(64'hAABB_CCDD_EE33_2211, 1'b1, 3'd3);
        chk1("bp_single", out_valid, 1'b0);
        wait_full(n);
        chk("mb_pad", 64'(n), 64'd17);
        chk("mb_w0", word_of(0), 64'h0633_2211);
        chk("mb_w17", word_of(17), TOP);
        chk1("mb_last2", out_last, 1'b1);
        handshake();

        // asynchronous reset mid-absorb
        drive(1'b1, 2'b10, 64'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int j = 0; j < 5; j++) send_word(64'hFFFF_0000_FFFF_0000, 1'b0, 3'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk1("ar_valid", out_valid, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk1("ar_ack", ack, 1'b0);
        chk1("ar_out_zero", out_blk == '0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 2'b10, 64'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        send_word(64'h1234, 1'b1, 3'd0);
        wait_full(n);
        chk("ar_pad", 64'(n), 64'd12);
        chk("ar_w0", word_of(0), 64'h06);
        chk("ar_w3", word_of(3), 64'h0);
        chk("ar_w12", word_of(12), TOP);
        handshake();

        // start during PAD aborts the message
        drive(1'b1, 2'b01, 64'h0, 1'b0, 1'b0, 3'd0, 1'b0);
        send_word(64'h0, 1'b1, 3'd0);
        idle();
        idle();
        idle();
        drive(1'b1, 2'b11, 64'h77, 1'b1, 1'b0, 3'd0, 1'b1);
        chk1("ab_start_ack", ack, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (out_valid) seen = 1'b1;
        end
        chk1("ab_no_valid", seen, 1'b0);
        send_word(64'h0, 1'b1, 3'd0);
        wait_full(n);
        chk("ab_pad", 64'(n), 64'd8);
        chk("ab_w8", word_of(8), TOP);
        chk("ab_w16", word_of(16), 64'h0);
        chk1("ab_last", out_last, 1'b1);
        handshake();

        // random messages against a byte-level padding model
        for (int t = 0; t < 25; t++) begin
            rm = 2'($urandom);
            rate = (rm == 2'b00) ? 18 : (rm == 2'b01) ? 17 :
                   (rm == 2'b10) ? 13 : 9;
            len = $urandom_range(0, 8 * (2 * rate + 3));
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            pb = msg;
            pb.push_back(8'h06);
            while (pb.size() % (rate * 8) != 0) pb.push_back(8'h00);
            pb[pb.size() - 1] = pb[pb.size() - 1] | 8'h80;
            nblk = pb.size() / (rate * 8);
            nfull = len / 8;
            rbn = 3'(len % 8);

            drive(1'b1, rm, 64'($urandom), 1'b1, 1'b0, 3'd0, 1'b0);
            chk1("rnd_start_ack", ack, 1'b0);
            widx = 0;
            bi = 0;
            cyc = 0;
            hold = 1'b0;
            while (bi < nblk && cyc < 3000) begin
                d = {$urandom, $urandom};
                for (int b = 0; b < 8; b++) begin
                    if (widx * 8 + b < len) d[8*b +: 8] = msg[widx * 8 + b];
                end
                v = (widx <= nfull) && ($urandom_range(0, 3) != 0);
                drive(1'b0, 2'($urandom), d, v, widx == nfull,
                      (widx == nfull) ? rbn : 3'($urandom),
                      $urandom_range(0, 1) == 1);
                cyc++;
                if (hold) begin
                    chk1("rnd_hold", out_valid === 1'b1 && out_blk === prev &&
                         out_last === prev_last, 1'b1);
                end
                if (out_valid) chk1("rnd_ack_full", ack, 1'b0);
                if (ack) widx++;
                hold = 1'b0;
                if (out_valid && out_ready) begin
                    for (int k = 0; k < MW; k++) begin
                        ew = '0;
                        if (k < rate) begin
                            for (int b = 0; b < 8; b++) begin
                                ew[8*b +: 8] = pb[bi * rate * 8 + k * 8 + b];
                            end
                        end
                        chk("rnd_word", word_of(k), ew);
                    end
                    chk1("rnd_last", out_last, bi == nblk - 1);
                    bi++;
                end else if (out_valid) begin
                    hold = 1'b1;
                    prev = out_blk;
                    prev_last = out_last;
                end
            end
            chk("rnd_blocks", 64'(bi), 64'(nblk));
            idle();
            chk1("rnd_idle", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
